wib_pwr_seq: RTL

WIB_PWR_SEQ -- requirements
Module: wib_pwr_seq

---
 rtl/wib_pwr_seq.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/wib_pwr_seq.sv
// WIB VP12 regulator power sequencer.
// Ramps regulator enables up in channel order and down in reverse order with a
// programmable step delay, and trips all channels off on an unblanked IV alert.
module wib_pwr_seq #(
    parameter int unsigned N_CH  = 6,
    parameter int unsigned DLY_W = 24
) (
    input  logic             clk_axi,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             clear_fault,
    input  logic [N_CH-1:0]  en_mask,
    input  logic [DLY_W-1:0] step_dly,
    input  logic [DLY_W-1:0] alert_blank,
    input  logic [N_CH-1:0]  alert,
    output logic [N_CH-1:0]  vp12_en,
    output logic             busy,
    output logic             fault,
    output logic [N_CH-1:0]  fault_ch,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StRampUp   = 3'd1,
        StOn       = 3'd2,
        StRampDown = 3'd3,
        StFault    = 3'd4
    } st_e;

    localparam int unsigned PW = 3;
    localparam logic [PW-1:0] PtrTop  = PW'(N_CH - 1);
    // Ramp-down pointer wraps past channel 0 to all-ones, marking the sweep done.
    localparam logic [PW-1:0] PtrDone = '1;

    st_e              st_q;
    logic [PW-1:0]    ptr_q;
    logic [DLY_W-1:0] cnt_q;
    logic [DLY_W-1:0] bcnt_q [N_CH];
    logic [N_CH-1:0]  en_q;
    logic [N_CH-1:0]  fault_ch_q;
    logic             busy_q;
    logic             fault_q;

    logic [N_CH-1:0]  armed;
    logic [N_CH-1:0]  trip_vec;
    logic             trip;
    logic [N_CH-1:0]  mask_rem;
    logic             ld_en;

    // Arming, trip detection and the ramp-up enable strobe.
    always_comb begin
        armed = '0;
        for (int i = 0; i < N_CH; i++) begin
            armed[i] = en_q[i] && (bcnt_q[i] == '0);
        end
        trip_vec = alert & armed;
        trip     = (|trip_vec) && (st_q != StFault);
        // Enabled channels still ahead of the pointer; trailing skips cost nothing.
        mask_rem = en_mask >> ptr_q;
        ld_en    = (st_q == StRampUp) && !stop && !trip && (cnt_q == '0) &&
                   (mask_rem != '0) && en_mask[ptr_q];
    end

    // Per-channel alert blanking: load on enable, count down, saturate at zero.
    always_ff @(posedge clk_axi or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                bcnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (ld_en && (ptr_q == PW'(i))) begin
                    bcnt_q[i] <= alert_blank;
                end else if (bcnt_q[i] != '0) begin
                    bcnt_q[i] <= bcnt_q[i] - 1'b1;
                end
            end
        end
    end

    // Sequencer FSM with registered enables, busy and sticky fault status.
    always_ff @(posedge clk_axi or posedge rst) begin
        if (rst) begin
            st_q       <= StIdle;
            ptr_q      <= '0;
            cnt_q      <= '0;
            en_q       <= '0;
            busy_q     <= 1'b0;
            fault_q    <= 1'b0;
            fault_ch_q <= '0;
        end else if (trip) begin
            st_q       <= StFault;
            en_q       <= '0;
            busy_q     <= 1'b0;
            fault_q    <= 1'b1;
            fault_ch_q <= fault_ch_q | trip_vec;
        end else begin
            unique case (st_q)
                StIdle: begin
                    if (start && !stop) begin
                        st_q   <= StRampUp;
                        ptr_q  <= '0;
                        cnt_q  <= '0;
                        busy_q <= 1'b1;
                    end
                end
                StRampUp: begin
                    if (stop) begin
                        st_q  <= StRampDown;
                        ptr_q <= PtrTop;
                        cnt_q <= '0;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (mask_rem == '0) begin
                        st_q   <= StOn;
                        busy_q <= 1'b0;
                    end else begin
                        if (ld_en) begin
                            en_q[ptr_q] <= 1'b1;
                            cnt_q       <= step_dly;
                        end
                        ptr_q <= ptr_q + 1'b1;
                    end
                end
                StOn: begin
                    if (stop) begin
                        st_q   <= StRampDown;
                        ptr_q  <= PtrTop;
                        cnt_q  <= '0;
                        busy_q <= 1'b1;
                    end
                end
                StRampDown: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (ptr_q == PtrDone) begin
                        st_q   <= StIdle;
                        ptr_q  <= '0;
                        busy_q <= 1'b0;
                    end else begin
                        if (en_q[ptr_q]) begin
                            en_q[ptr_q] <= 1'b0;
                            cnt_q       <= step_dly;
                        end
                        ptr_q <= ptr_q - 1'b1;
                    end
                end
                StFault: begin
                    if (clear_fault) begin
                        st_q       <= StIdle;
                        fault_q    <= 1'b0;
                        fault_ch_q <= '0;
                    end
                end
                default: st_q <= StIdle;
            endcase
        end
    end

    assign vp12_en  = en_q;
    assign busy     = busy_q;
    assign fault    = fault_q;
    assign fault_ch = fault_ch_q;
    assign state    = st_q;

endmodule
